// File: rtl/ctrl_mc.sv
// Multi-cycle RV32I(+M) control unit: decodes a registered instruction and sequences
// execute, memory, mul/div wait, write-back and trap phases.
module ctrl_mc #(
  parameter int EN_M        = 1,
  parameter int MEM_TIMEOUT = 255,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inst_valid,
  input  logic [6:0]       opcode,
  input  logic [2:0]       func3,
  input  logic [6:0]       func7,
  input  logic             mem_ready,
  input  logic             md_done,
  input  logic             flush,
  output logic             inst_ready,
  output logic             pc_we,
  output logic             rwen,
  output logic             mreq,
  output logic             mwen,
  output logic             ASel,
  output logic             BSel,
  output logic [1:0]       bj,
  output logic [1:0]       wbSel,
  output logic [2:0]       lsWidth,
  output logic [3:0]       ALUOp,
  output logic [2:0]       BOp,
  output logic             md_start,
  output logic [2:0]       md_op,
  output logic             illegal,
  output logic [CNT_W-1:0] retired
);

  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_B     = 7'b1100011;
  localparam logic [6:0] OP_L     = 7'b0000011;
  localparam logic [6:0] OP_S     = 7'b0100011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_R     = 7'b0110011;

  // The wait counter only needs to reach MEM_TIMEOUT-1.
  localparam int WAIT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_EXEC   = 3'd1,
    S_MEM    = 3'd2,
    S_MDWAIT = 3'd3,
    S_WB     = 3'd4,
    S_TRAP   = 3'd5
  } state_t;

  state_t            state_r, state_nxt_s;
  logic [6:0]        op_r, f7_r;
  logic [2:0]        f3_r;
  logic [WAIT_W-1:0] wait_r;
  logic              flush_lat_r;
  logic [CNT_W-1:0]  retired_r;

  logic       legal_s, is_m_s, is_l_s, is_s_s, no_rw_s;
  logic       active_s, flush_eff_s, timeout_s, retire_s;
  logic       dec_asel_s, dec_bsel_s;
  logic [1:0] dec_bj_s, dec_wb_s;
  logic [2:0] dec_ls_s, dec_bop_s;
  logic [3:0] dec_alu_s;

  assign is_m_s  = (EN_M != 0) && (op_r == OP_R) && (f7_r == 7'b0000001);
  assign is_l_s  = (op_r == OP_L);
  assign is_s_s  = (op_r == OP_S);
  assign no_rw_s = (op_r == OP_S) || (op_r == OP_B);

  // Legality check on the registered instruction fields
  always_comb begin
    legal_s = 1'b0;
    case (op_r)
      OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_B, OP_L, OP_S, OP_I: legal_s = 1'b1;
      OP_R: legal_s = (f7_r == 7'b0000000)
                   || ((f7_r == 7'b0100000) && ((f3_r == 3'b000) || (f3_r == 3'b101)))
                   || ((f7_r == 7'b0000001) && (EN_M != 0));
      default: legal_s = 1'b0;
    endcase
  end

  // Datapath control decode from the registered fields
  always_comb begin
    dec_asel_s = 1'b0;
    dec_bsel_s = 1'b0;
    dec_bj_s   = 2'b00;
    dec_wb_s   = 2'b01;
    dec_ls_s   = 3'b000;
    dec_bop_s  = 3'b000;
    dec_alu_s  = 4'b0000;
    case (op_r)
      OP_LUI:   dec_bsel_s = 1'b1;
      OP_AUIPC: begin
        dec_asel_s = 1'b1;
        dec_bsel_s = 1'b1;
      end
      OP_JAL: begin
        dec_asel_s = 1'b1;
        dec_bsel_s = 1'b1;
        dec_bj_s   = 2'b01;
        dec_wb_s   = 2'b10;
      end
      OP_JALR: begin
        dec_bsel_s = 1'b1;
        dec_bj_s   = 2'b01;
        dec_wb_s   = 2'b10;
      end
      OP_B: begin
        dec_asel_s = 1'b1;
        dec_bsel_s = 1'b1;
        dec_bj_s   = 2'b10;
        dec_bop_s  = f3_r;
      end
      OP_L: begin
        dec_bsel_s = 1'b1;
        dec_wb_s   = 2'b00;
        dec_ls_s   = f3_r;
      end
      OP_S: begin
        dec_bsel_s = 1'b1;
        dec_ls_s   = f3_r;
      end
      OP_I: begin
        dec_bsel_s = 1'b1;
        dec_alu_s  = {(f3_r == 3'b101) & f7_r[5], f3_r};
      end
      OP_R: begin
        if (is_m_s) begin
          dec_wb_s = 2'b11;
        end else begin
          dec_alu_s = {((f3_r == 3'b000) || (f3_r == 3'b101)) & f7_r[5], f3_r};
        end
      end
      default: dec_wb_s = 2'b01;
    endcase
  end

  // A flush seen during MEM is remembered; a flush in the completing cycle counts too.
  assign flush_eff_s = flush_lat_r | flush;
  assign timeout_s   = (MEM_TIMEOUT > 0) && !mem_ready && (wait_r == WAIT_LAST);

  // Next-state selection
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      S_IDLE: begin
        if (inst_valid) state_nxt_s = S_EXEC;
        else            state_nxt_s = S_IDLE;
      end
      S_EXEC: begin
        if (flush)                  state_nxt_s = S_IDLE;
        else if (!legal_s)          state_nxt_s = S_TRAP;
        else if (is_l_s || is_s_s)  state_nxt_s = S_MEM;
        else if (is_m_s)            state_nxt_s = S_MDWAIT;
        else                        state_nxt_s = S_WB;
      end
      S_MEM: begin
        if (mem_ready) begin
          if (is_l_s && !flush_eff_s) state_nxt_s = S_WB;
          else                        state_nxt_s = S_IDLE;
        end else if (timeout_s) begin
          state_nxt_s = S_TRAP;
        end else begin
          state_nxt_s = S_MEM;
        end
      end
      S_MDWAIT: begin
        if (flush)        state_nxt_s = S_IDLE;
        else if (md_done) state_nxt_s = S_WB;
        else              state_nxt_s = S_MDWAIT;
      end
      S_WB:    state_nxt_s = S_IDLE;
      S_TRAP:  state_nxt_s = S_IDLE;
      default: state_nxt_s = S_IDLE;
    endcase
  end

  // State, captured instruction, MEM wait/flush tracking and retire counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= S_IDLE;
      op_r        <= 7'd0;
      f3_r        <= 3'd0;
      f7_r        <= 7'd0;
      wait_r      <= '0;
      flush_lat_r <= 1'b0;
      retired_r   <= '0;
    end else begin
      state_r <= state_nxt_s;
      if ((state_r == S_IDLE) && inst_valid) begin
        op_r <= opcode;
        f3_r <= func3;
        f7_r <= func7;
      end
      if (state_r == S_EXEC) begin
        wait_r <= '0;
      end else if ((state_r == S_MEM) && !mem_ready) begin
        wait_r <= wait_r + WAIT_W'(1);
      end
      if ((state_r == S_MEM) && (state_nxt_s == S_MEM)) begin
        flush_lat_r <= flush_eff_s;
      end else begin
        flush_lat_r <= 1'b0;
      end
      if (retire_s) begin
        retired_r <= retired_r + CNT_W'(1);
      end
    end
  end

  assign active_s = (state_r == S_EXEC) || (state_r == S_MEM)
                 || (state_r == S_MDWAIT) || (state_r == S_WB);

  assign retire_s = ((state_r == S_WB) && !flush)
                 || ((state_r == S_MEM) && mem_ready && is_s_s && !flush_eff_s);

  assign inst_ready = (state_r == S_IDLE);
  assign pc_we      = retire_s;
  assign rwen       = (state_r == S_WB) && !flush && !no_rw_s;
  assign mreq       = (state_r == S_MEM);
  assign mwen       = (state_r == S_MEM) && is_s_s;
  assign md_start   = (state_r == S_EXEC) && !flush && legal_s && is_m_s;
  assign md_op      = (state_r == S_MDWAIT) ? f3_r : 3'b000;
  assign illegal    = (state_r == S_TRAP);
  assign retired    = retired_r;

  assign ASel    = active_s ? dec_asel_s : 1'b0;
  assign BSel    = active_s ? dec_bsel_s : 1'b0;
  assign bj      = active_s ? dec_bj_s   : 2'b00;
  assign wbSel   = active_s ? dec_wb_s   : 2'b00;
  assign lsWidth = active_s ? dec_ls_s   : 3'b000;
  assign ALUOp   = active_s ? dec_alu_s  : 4'b0000;
  assign BOp     = active_s ? dec_bop_s  : 3'b000;

endmodule

// File: tb/tb_ctrl_mc.sv
// Randomized bench for ctrl_mc: instance a (EN_M=1, timeout 4, 4-bit counter) and
// instance b (EN_M=0, no timeout) are checked against a per-instruction phase model.
module tb_ctrl_mc;

  logic clk = 1'b0;
  logic rst_n;
  logic inst_valid_a, inst_valid_b, mem_ready, md_done, flush;
  logic [6:0] opcode, func7;
  logic [2:0] func3;

  logic pc_we_a, rwen_a, mreq_a, mwen_a, ir_a, asel_a, bsel_a, mds_a, ill_a;
  logic [1:0] bj_a, wb_a;
  logic [2:0] ls_a, bop_a, mdop_a;
  logic [3:0] alu_a;
  logic [3:0] ret_a;
  logic pc_we_b, rwen_b, mreq_b, mwen_b, ir_b, asel_b, bsel_b, mds_b, ill_b;
  logic [1:0] bj_b, wb_b;
  logic [2:0] ls_b, bop_b, mdop_b;
  logic [3:0] alu_b;
  logic [31:0] ret_b;

  always #5 clk = ~clk;

  ctrl_mc #(.EN_M(1), .MEM_TIMEOUT(4), .CNT_W(4)) dut_a (
    .clk(clk), .rst_n(rst_n), .inst_valid(inst_valid_a), .opcode(opcode), .func3(func3),
    .func7(func7), .mem_ready(mem_ready), .md_done(md_done), .flush(flush),
    .inst_ready(ir_a), .pc_we(pc_we_a), .rwen(rwen_a), .mreq(mreq_a), .mwen(mwen_a),
    .ASel(asel_a), .BSel(bsel_a), .bj(bj_a), .wbSel(wb_a), .lsWidth(ls_a), .ALUOp(alu_a),
    .BOp(bop_a), .md_start(mds_a), .md_op(mdop_a), .illegal(ill_a), .retired(ret_a));

  ctrl_mc #(.EN_M(0), .MEM_TIMEOUT(0), .CNT_W(32)) dut_b (
    .clk(clk), .rst_n(rst_n), .inst_valid(inst_valid_b), .opcode(opcode), .func3(func3),
    .func7(func7), .mem_ready(mem_ready), .md_done(md_done), .flush(flush),
    .inst_ready(ir_b), .pc_we(pc_we_b), .rwen(rwen_b), .mreq(mreq_b), .mwen(mwen_b),
    .ASel(asel_b), .BSel(bsel_b), .bj(bj_b), .wbSel(wb_b), .lsWidth(ls_b), .ALUOp(alu_b),
    .BOp(bop_b), .md_start(mds_b), .md_op(mdop_b), .illegal(ill_b), .retired(ret_b));

  // Output vector layout: ir pc rw mreq mwen asel bsel bj[2] wb[2] ls[3] alu[4] bop[3] mds mdop[3] ill
  localparam int B_IR = 25, B_PC = 24, B_RW = 23, B_MREQ = 22, B_MWEN = 21, B_MDS = 4;
  localparam logic [25:0] IDLE_VEC = 26'h2000000;
  localparam logic [25:0] TRAP_VEC = 26'h0000001;

  wire [25:0] obs_a = {ir_a, pc_we_a, rwen_a, mreq_a, mwen_a, asel_a, bsel_a, bj_a, wb_a,
                       ls_a, alu_a, bop_a, mds_a, mdop_a, ill_a};
  wire [25:0] obs_b = {ir_b, pc_we_b, rwen_b, mreq_b, mwen_b, asel_b, bsel_b, bj_b, wb_b,
                       ls_b, alu_b, bop_b, mds_b, mdop_b, ill_b};

  int n_chk = 0;
  int n_pass = 0;
  int ret_m[2];

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: observed %h expected %h at %0t", tag, obs, exp, $time);
  endtask

  function automatic bit is_legal(input logic [6:0] op, input logic [2:0] f3,
                                  input logic [6:0] f7, input bit en_m);
    case (op)
      7'h37, 7'h17, 7'h6f, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13: return 1'b1;
      7'h33: return (f7 == 7'h00) || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5))
                 || (f7 == 7'h01 && en_m);
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [25:0] dec_fields(input logic [6:0] op, input logic [2:0] f3,
                                             input logic [6:0] f7, input bit en_m);
    logic a, b;
    logic [1:0] bjv, wbv;
    logic [2:0] ls, bop;
    logic [3:0] alu;
    a = 1'b0; b = 1'b0; bjv = 2'b00; wbv = 2'b01; ls = 3'd0; bop = 3'd0; alu = 4'd0;
    case (op)
      7'h37: b = 1'b1;
      7'h17: begin a = 1'b1; b = 1'b1; end
      7'h6f: begin a = 1'b1; b = 1'b1; bjv = 2'b01; wbv = 2'b10; end
      7'h67: begin b = 1'b1; bjv = 2'b01; wbv = 2'b10; end
      7'h63: begin a = 1'b1; b = 1'b1; bjv = 2'b10; bop = f3; end
      7'h03: begin b = 1'b1; wbv = 2'b00; ls = f3; end
      7'h23: begin b = 1'b1; ls = f3; end
      7'h13: begin b = 1'b1; alu = {(f3 == 3'd5) & f7[5], f3}; end
      7'h33: begin
        if (en_m && f7 == 7'h01) wbv = 2'b11;
        else alu = {((f3 == 3'd0) || (f3 == 3'd5)) & f7[5], f3};
      end
      default: ;
    endcase
    return {5'b00000, a, b, bjv, wbv, ls, alu, bop, 5'b00000};
  endfunction

  // One clock cycle: drive, sample at negedge, then advance past the rising edge.
  task automatic step(input int sel, input logic iv, input logic fl, input logic mr,
                      input logic mdd, input logic [25:0] exp, input bit inc, input string tag);
    inst_valid_a = iv && (sel == 0);
    inst_valid_b = iv && (sel == 1);
    flush = fl; mem_ready = mr; md_done = mdd;
    if (!iv) begin
      opcode = 7'($urandom); func3 = 3'($urandom); func7 = 7'($urandom);
    end
    @(negedge clk);
    if (sel == 0) begin
      check_val(tag, 64'(obs_a), 64'(exp));
      check_val({tag, "_retired"}, 64'(ret_a), 64'(ret_m[0] & 15));
      check_val("b_stays_idle", 64'(obs_b), 64'(IDLE_VEC));
    end else begin
      check_val(tag, 64'(obs_b), 64'(exp));
      check_val({tag, "_retired"}, 64'(ret_b), 64'(unsigned'(ret_m[1])));
      check_val("a_stays_idle", 64'(obs_a), 64'(IDLE_VEC));
    end
    @(posedge clk);
    #1;
    if (inc) ret_m[sel]++;
    inst_valid_a = 1'b0; inst_valid_b = 1'b0; flush = 1'b0; mem_ready = 1'b0; md_done = 1'b0;
  endtask

  // Whole-instruction model: lat = cycles before mem_ready/md_done, fo = cycle index of flush.
  task automatic run_inst(input int sel, input logic [6:0] op, input logic [2:0] f3,
                          input logic [6:0] f7, input int lat, input int fo);
    bit en_m, m, lg, isl, iss, nrw, fl, flat, rdy, go_wb;
    int to, t;
    logic [25:0] fld, v;
    en_m = (sel == 0);
    to   = (sel == 0) ? 4 : 0;
    fld  = dec_fields(op, f3, f7, en_m);
    lg   = is_legal(op, f3, f7, en_m);
    m    = en_m && op == 7'h33 && f7 == 7'h01;
    isl  = (op == 7'h03);
    iss  = (op == 7'h23);
    nrw  = iss || (op == 7'h63);
    opcode = op; func3 = f3; func7 = f7;
    step(sel, 1'b1, 1'b0, 1'b0, 1'b0, IDLE_VEC, 1'b0, "idle_accept");
    t = 1;
    fl = (fo == 1);
    v = fld;
    v[B_MDS] = m && !fl;
    step(sel, 1'b0, fl, 1'b0, 1'b0, v, 1'b0, "exec");
    if (fl) return;
    if (!lg) begin
      step(sel, 1'b0, 1'b0, 1'b0, 1'b0, TRAP_VEC, 1'b0, "trap_illegal");
      return;
    end
    go_wb = 1'b0;
    if (isl || iss) begin
      flat = 1'b0;
      for (int c = 0; c < 64; c++) begin
        t = 2 + c;
        fl = (t == fo);
        rdy = (c == lat);
        flat = flat | fl;
        v = fld;
        v[B_MREQ] = 1'b1;
        v[B_MWEN] = iss;
        v[B_PC] = rdy && iss && !flat;
        step(sel, 1'b0, fl, rdy, 1'b0, v, rdy && iss && !flat, "mem");
        if (rdy) begin
          go_wb = isl && !flat;
          break;
        end
        if (to > 0 && c == to - 1) begin
          step(sel, 1'b0, 1'b0, 1'b0, 1'b0, TRAP_VEC, 1'b0, "trap_timeout");
          return;
        end
      end
    end else if (m) begin
      for (int c = 0; c < 64; c++) begin
        t = 2 + c;
        fl = (t == fo);
        rdy = (c == lat);
        v = fld;
        v[3:1] = f3;
        step(sel, 1'b0, fl, 1'b0, rdy, v, 1'b0, "mdwait");
        if (fl) return;
        if (rdy) begin
          go_wb = 1'b1;
          break;
        end
      end
    end else begin
      go_wb = 1'b1;
    end
    if (go_wb) begin
      t++;
      fl = (t == fo);
      v = fld;
      v[B_PC] = !fl;
      v[B_RW] = !fl && !nrw;
      step(sel, 1'b0, fl, 1'b0, 1'b0, v, !fl, "wb");
    end
  endtask

  logic [6:0] op_tab [10];
  logic [6:0] rop, rf7;
  logic [25:0] rv;

  initial begin
    op_tab = '{7'h37, 7'h17, 7'h6f, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33, 7'h7f};
    ret_m[0] = 0; ret_m[1] = 0;
    rst_n = 1'b0;
    inst_valid_a = 1'b0; inst_valid_b = 1'b0; flush = 1'b0; mem_ready = 1'b0; md_done = 1'b0;
    opcode = 7'd0; func3 = 3'd0; func7 = 7'd0;
    #12;
    check_val("reset_a_outputs", 64'(obs_a), 64'(IDLE_VEC));
    check_val("reset_a_retired", 64'(ret_a), 64'd0);
    check_val("reset_b_outputs", 64'(obs_b), 64'(IDLE_VEC));
    check_val("reset_b_retired", 64'(ret_b), 64'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    run_inst(0, 7'h33, 3'd0, 7'h00, 0, 0);   // ADD
    run_inst(0, 7'h33, 3'd0, 7'h20, 0, 0);   // SUB
    run_inst(0, 7'h13, 3'd5, 7'h20, 0, 0);   // SRAI
    run_inst(0, 7'h23, 3'd2, 7'h15, 2, 0);   // SW, ready on 3rd MEM cycle
    run_inst(0, 7'h33, 3'd0, 7'h01, 5, 0);   // MUL
    run_inst(1, 7'h33, 3'd0, 7'h01, 5, 0);   // MUL without M extension
    run_inst(0, 7'h03, 3'd2, 7'h00, 40, 0);  // LW timeout
    run_inst(1, 7'h03, 3'd2, 7'h00, 9, 0);   // LW long wait, timeout disabled
    run_inst(0, 7'h03, 3'd2, 7'h00, 3, 3);   // LW flushed during MEM
    run_inst(0, 7'h23, 3'd1, 7'h00, 1, 2);   // SH flushed during MEM
    run_inst(0, 7'h33, 3'd0, 7'h00, 0, 1);   // flush in EXEC
    run_inst(0, 7'h6f, 3'd0, 7'h00, 0, 2);   // JAL flushed in WB
    run_inst(0, 7'h33, 3'd4, 7'h01, 6, 4);   // DIV flushed in MDWAIT
    run_inst(0, 7'h7f, 3'd0, 7'h00, 0, 0);   // illegal opcode
    run_inst(0, 7'h33, 3'd1, 7'h20, 0, 0);   // illegal func7/func3 pairing

    for (int i = 0; i < 300; i++) begin
      int k;
      k = $urandom_range(0, 9);
      rop = (k == 9) ? 7'($urandom) : op_tab[k];
      case ($urandom_range(0, 3))
        0: rf7 = 7'h00;
        1: rf7 = 7'h20;
        2: rf7 = 7'h01;
        default: rf7 = 7'($urandom);
      endcase
      run_inst($urandom_range(0, 3) == 0 ? 1 : 0, rop, 3'($urandom), rf7,
               $urandom_range(0, 6), ($urandom_range(0, 3) == 0) ? $urandom_range(1, 8) : 0);
    end

    // Asynchronous reset while waiting on the mul/div unit
    opcode = 7'h33; func3 = 3'd3; func7 = 7'h01;
    step(0, 1'b1, 1'b0, 1'b0, 1'b0, IDLE_VEC, 1'b0, "rst_accept");
    rv = dec_fields(7'h33, 3'd3, 7'h01, 1'b1);
    rv[B_MDS] = 1'b1;
    step(0, 1'b0, 1'b0, 1'b0, 1'b0, rv, 1'b0, "rst_exec");
    rv[B_MDS] = 1'b0;
    rv[3:1] = 3'd3;
    step(0, 1'b0, 1'b0, 1'b0, 1'b0, rv, 1'b0, "rst_mdwait");
    step(0, 1'b0, 1'b0, 1'b0, 1'b0, rv, 1'b0, "rst_mdwait");
    #2;
    rst_n = 1'b0;
    #1;
    check_val("async_reset_a_outputs", 64'(obs_a), 64'(IDLE_VEC));
    check_val("async_reset_a_retired", 64'(ret_a), 64'd0);
    check_val("async_reset_b_retired", 64'(ret_b), 64'd0);
    ret_m[0] = 0; ret_m[1] = 0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    run_inst(0, 7'h33, 3'd0, 7'h00, 0, 0);
    run_inst(0, 7'h37, 3'd0, 7'h00, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
